// File: rtl/serv_decode_q.sv
// Two-entry buffered instruction decoder: an active slot (A) driving the decoded outputs
// and a prefetch slot (B). Slots hold either decoded control or raw words (PRE_REGISTER).
module serv_decode_q #(
  parameter bit PRE_REGISTER = 1'b1,
  parameter bit MDU          = 1'b1,
  parameter bit ILLEGAL_CHK  = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_en,
  output logic        o_wb_rdy,
  input  logic        i_adv,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [2:0]  o_funct3,
  output logic        o_imm30,
  output logic        o_mem_op,
  output logic        o_shift_op,
  output logic        o_slt_op,
  output logic        o_branch_op,
  output logic        o_rd_op,
  output logic        o_e_op,
  output logic        o_mret,
  output logic        o_csr_op,
  output logic        o_alu_sub,
  output logic        o_op_b_source,
  output logic        o_mdu_op,
  output logic        o_illegal,
  output logic [3:0]  o_immdec_ctrl
);

  typedef struct packed {
    logic [2:0] funct3;
    logic       imm30;
    logic       mem_op;
    logic       shift_op;
    logic       slt_op;
    logic       branch_op;
    logic       rd_op;
    logic       e_op;
    logic       mret;
    logic       csr_op;
    logic       alu_sub;
    logic       op_b_source;
    logic       mdu_op;
    logic       illegal;
    logic [3:0] immdec_ctrl;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op;
    logic       is_alu;
    logic       legal_op;
    logic       legal_f7;
    op       = w[6:2];
    f3       = w[14:12];
    f7       = w[31:25];
    is_op    = (op == 5'b01100);
    is_alu   = is_op | (op == 5'b00100);
    unique case (op)
      5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011, 5'b00100,
      5'b01100, 5'b00101, 5'b01101, 5'b11100, 5'b00011: legal_op = 1'b1;
      default:                                          legal_op = 1'b0;
    endcase
    legal_f7 = !is_op || (f7 == 7'b0000000) || (f7 == 7'b0100000) ||
               (MDU && (f7 == 7'b0000001));

    d.funct3         = f3;
    d.imm30          = w[30];
    d.mem_op         = (op == 5'b00000) | (op == 5'b01000);
    d.branch_op      = op[4] & ~op[2];
    d.shift_op       = is_alu & (f3[1:0] == 2'b01);
    d.slt_op         = is_alu & (f3[2:1] == 2'b01);
    d.rd_op          = !((op == 5'b01000) | (op == 5'b11000) | (op == 5'b00011));
    d.e_op           = (op == 5'b11100) & (f3 == 3'b000) & ~w[21];
    d.mret           = (op == 5'b11100) & (f3 == 3'b000) & w[21];
    d.csr_op         = (op == 5'b11100) & (f3 != 3'b000);
    d.alu_sub        = (~f3[2] & (f3[0] | (op[3] & w[30]))) | f3[1] | op[4];
    d.op_b_source    = op[3];
    d.mdu_op         = MDU & is_op & (f7 == 7'b0000001);
    d.immdec_ctrl[0] = (op[3:0] == 4'b1000);
    d.immdec_ctrl[1] = (op[1:0] == 2'b00) | (op[2:1] == 2'b00);
    d.immdec_ctrl[2] = op[4] & ~op[0];
    d.immdec_ctrl[3] = op[4];
    d.illegal        = ILLEGAL_CHK & ((w[1:0] != 2'b11) | ~legal_op | ~legal_f7);
    return d;
  endfunction

  localparam int unsigned PayloadW = PRE_REGISTER ? $bits(dec_t) : 32;

  logic [PayloadW-1:0] a_q, a_d, b_q, b_d, push_payload;
  logic                va_q, va_d, vb_q, vb_d;
  logic                pop, push;
  dec_t                a_dec, out_dec;

  if (PRE_REGISTER) begin : g_pre
    assign push_payload = decode(i_wb_rdt);
    assign a_dec        = dec_t'(a_q);
  end else begin : g_post
    assign push_payload = i_wb_rdt;
    assign a_dec        = decode(a_q);
  end

  always_comb begin
    pop      = i_adv & va_q;
    o_wb_rdy = ~vb_q | pop;
    push     = i_wb_en & o_wb_rdy;
    va_d     = va_q;
    vb_d     = vb_q;
    a_d      = a_q;
    b_d      = b_q;
    if (i_flush) begin
      va_d = 1'b0;
      vb_d = 1'b0;
    end else begin
      if (pop) begin
        a_d  = b_q;
        va_d = vb_q;
        vb_d = 1'b0;
      end
      // The push lands in whichever slot is first free after the pop.
      if (push) begin
        if (!va_d) begin
          a_d  = push_payload;
          va_d = 1'b1;
        end else begin
          b_d  = push_payload;
          vb_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
    end
  end

  // Slot contents are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign out_dec       = va_q ? a_dec : '0;
  assign o_valid       = va_q;
  assign o_funct3      = out_dec.funct3;
  assign o_imm30       = out_dec.imm30;
  assign o_mem_op      = out_dec.mem_op;
  assign o_shift_op    = out_dec.shift_op;
  assign o_slt_op      = out_dec.slt_op;
  assign o_branch_op   = out_dec.branch_op;
  assign o_rd_op       = out_dec.rd_op;
  assign o_e_op        = out_dec.e_op;
  assign o_mret        = out_dec.mret;
  assign o_csr_op      = out_dec.csr_op;
  assign o_alu_sub     = out_dec.alu_sub;
  assign o_op_b_source = out_dec.op_b_source;
  assign o_mdu_op      = out_dec.mdu_op;
  assign o_illegal     = out_dec.illegal;
  assign o_immdec_ctrl = out_dec.immdec_ctrl;

  // A push into a full queue is dropped; it is only legitimate alongside a flush.
  a_push_when_full: assert property (@(posedge clk) disable iff (i_rst)
    !(i_wb_en && !o_wb_rdy && !i_flush));

endmodule
